instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Front-end sequencer for the simple computer. It owns the memory address/enable lines during instruction fetch, and reads 24-bit words from the 128-cell synchronous memory at the program counter. It splits each word into opcode, register, operand and addressing-mode fields and hands the result to the execute stage over a valid/ready handshake. It also accepts jump redirects from execute, yields the memory bus when execute needs it for operand access, and supports halt.

## Interface
- RESET_PC, 8'd20: PC value after reset.
- ADDR_W, 8: address width of MAR/PC.
- clk  in  1  clock, all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- mem_MAR  out  8  memory address. Equals PC while fetching.
- mem_EN  out  1  memory enable. High only in REQ with bus_busy=0.
- mem_CS  out  1  memory read/write select. Constant 0 (read).
- mem_data_out  in  24  memory read data. Valid the cycle after an enabled read edge.
- bus_busy  in  1  execute stage owns memory. Fetch must not assert mem_EN.
- instr_valid  out  1  decoded instruction available.
- instr_ready  in  1  execute accepts the instruction.
- instr_word  out  24  raw fetched word.
- opcode  out  4  instr_word[18:15].
- reg_sel  out  4  instr_word[14:11].
- operand  out  8  instr_word[10:3].
- mode  out  3  instr_word[2:0].
- instr_pc  out  8  address the held word was fetched from.
- redirect_valid  in  1  jump request.
- redirect_addr  in  8  jump target.
- halt  in  1  stop issuing new fetches.
- illegal  out  1  illegal-instruction flag. Only present with IFU_ILLEGAL_CHECK_EN.

## Operation
- FSM states: IDLE, REQ, WAIT, VALID.
- IDLE: go to REQ when halt=0.
- REQ: drive mem_MAR=PC and mem_EN=!bus_busy. Go to WAIT only in a cycle with bus_busy=0; otherwise stay in REQ.
- WAIT: at the end of the cycle, capture mem_data_out into the instruction register and set instr_pc=PC. Increment PC and go to VALID.
- VALID: instr_valid=1. Outputs are held stable until accepted. When instr_ready=1: go to REQ if halt=0, otherwise go to IDLE.
- PC arithmetic: 7 bits wide, wraps 127→0. mem_MAR[7] is always 0.
- Redirect: redirect_valid=1 in any state loads PC=redirect_addr[6:0] and goes to REQ (IDLE if halt=1).
  - A read in flight in WAIT is discarded.
  - A held word in VALID is dropped and instr_valid falls next cycle.
  - Redirect wins over a simultaneous instr_ready handshake; that instruction counts as accepted and is not re-presented.
- halt has no effect on an in-flight fetch. That fetch completes and its word is presented.
- Reset values:
  - state=IDLE, PC=RESET_PC.
  - mem_EN=0, mem_MAR=0.
  - instr_valid=0, instr_word=0, all fields 0.
  - instr_pc=0, illegal=0.
- Reset mid-operation: any in-flight read is abandoned. A memory data_out arriving after reset is ignored.

## Timing
- Fetch latency: REQ at edge N → data captured at edge N+2 → instr_valid high from N+2.
- Throughput: one instruction per 3 cycles with instr_ready held high and no bus_busy.
- Every bus_busy cycle in REQ adds one cycle.
- mem_EN, mem_MAR: combinational from state/PC/bus_busy.
- All fields, instr_valid and illegal: registered.
- Redirect takes effect on the next edge. The first fetch from the target starts in the following REQ cycle.

## Configuration
- IFU_ILLEGAL_CHECK_EN defined:
  - illegal=1 alongside instr_valid when opcode ∉ {0000,0001,0011,0111,1011,1100,1101,1110,1111}, or mode>3'b100, or instr_word[23:19]≠0.
  - An illegal instruction is still presented. After acceptance the FSM goes to IDLE and stays there until reset or redirect.
- IFU_ILLEGAL_CHECK_EN undefined: the illegal port and its logic are absent, and every word is presented.

## Test plan
- Reset, memory[20]=24'h0188F0, instr_ready=1 → mem_EN at cycle 1 with MAR=20; instr_valid at cycle 3 with opcode=3, reg_sel=1, operand=30, mode=0, instr_pc=20.
- Program at 20..23, ready held high → fetches at MAR 20,21,22,23 spaced 3 cycles apart; 4 valids in order.
- instr_ready low for 5 cycles in VALID → outputs stable, no mem_EN asserted, PC=21 held.
- bus_busy high 2 cycles in REQ → mem_EN=0 those cycles; instr_valid delayed by exactly 2 cycles.
- redirect_valid with addr=40 while in WAIT for address 22 → word 22 never presented; next fetch MAR=40. Separately, PC=127 → next MAR=0.
- With IFU_ILLEGAL_CHECK_EN, memory word opcode 0010 → illegal=1 with instr_valid; after accept, no further mem_EN until redirect.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit memory bus, instruction handshake and control signals
// IFU_ILLEGAL_CHECK_EN adds the illegal flag to the bundle.
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] mem_MAR;
   logic              mem_EN;
   logic              mem_CS;
   logic [23:0]       mem_data_out;
   logic              bus_busy;
   logic              instr_valid;
   logic              instr_ready;
   logic [23:0]       instr_word;
   logic [3:0]        opcode;
   logic [3:0]        reg_sel;
   logic [7:0]        operand;
   logic [2:0]        mode;
   logic [ADDR_W-1:0] instr_pc;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_addr;
   logic              halt;
`ifdef IFU_ILLEGAL_CHECK_EN
   logic              illegal;
`endif

   modport master (
      output mem_MAR, mem_EN, mem_CS,
      input  mem_data_out, bus_busy,
      output instr_valid, instr_word, opcode, reg_sel, operand, mode, instr_pc,
`ifdef IFU_ILLEGAL_CHECK_EN
      output illegal,
`endif
      input  instr_ready, redirect_valid, redirect_addr, halt
   );

   modport slave (
      input  mem_MAR, mem_EN, mem_CS,
      output mem_data_out, bus_busy,
      input  instr_valid, instr_word, opcode, reg_sel, operand, mode, instr_pc,
`ifdef IFU_ILLEGAL_CHECK_EN
      input  illegal,
`endif
      output instr_ready, redirect_valid, redirect_addr, halt
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch sequencer: PC, memory read, decode, valid/ready hand-off
// IFU_ILLEGAL_CHECK_EN enables illegal-instruction detection and stop-after-illegal.
module instr_fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'd20,
   parameter int         ADDR_W   = 8
) (
   input logic                clk,
   input logic                rst,
   instr_fetch_unit_if.master bus
);
   localparam int PC_W = ADDR_W - 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_t;

   state_t          state;
   state_t          next_state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] ir_pc;
   logic [23:0]     ir;
   logic            valid_q;
   logic            stopped;
   logic            stop_after;

   // The top address bit is never part of the 128-cell space.
   logic unused_ok;
   assign unused_ok = &{1'b0, bus.redirect_addr[ADDR_W-1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pc      <= RESET_PC[PC_W-1:0];
         ir      <= '0;
         ir_pc   <= '0;
         valid_q <= 1'b0;
      end else begin
         state   <= next_state;
         valid_q <= (next_state == VALID);
         if (bus.redirect_valid) begin
            pc <= bus.redirect_addr[PC_W-1:0];
         end else if (state == WAIT) begin
            ir    <= bus.mem_data_out;
            ir_pc <= pc;
            pc    <= pc + 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!bus.halt && !stopped) next_state = REQ;
         REQ:     if (!bus.bus_busy) next_state = WAIT;
         WAIT:    next_state = VALID;
         VALID:   if (bus.instr_ready) next_state = (bus.halt || stop_after) ? IDLE : REQ;
         default: next_state = IDLE;
      endcase
      // A jump overrides everything, including a same-cycle handshake.
      if (bus.redirect_valid) next_state = bus.halt ? IDLE : REQ;
   end

   always_comb begin
      bus.mem_EN  = 1'b0;
      bus.mem_MAR = '0;
      if (state == REQ) begin
         bus.mem_MAR = {1'b0, pc};
         bus.mem_EN  = !bus.bus_busy;
      end else if (state == WAIT) begin
         bus.mem_MAR = {1'b0, pc};
      end
   end

   assign bus.mem_CS      = 1'b0;
   assign bus.instr_valid = valid_q;
   assign bus.instr_word  = ir;
   assign bus.opcode      = ir[18:15];
   assign bus.reg_sel     = ir[14:11];
   assign bus.operand     = ir[10:3];
   assign bus.mode        = ir[2:0];
   assign bus.instr_pc    = {1'b0, ir_pc};

`ifdef IFU_ILLEGAL_CHECK_EN
   logic illegal_q;

   function automatic logic is_illegal(input logic [23:0] w);
      logic bad_op;
      case (w[18:15])
         4'b0000, 4'b0001, 4'b0011, 4'b0111,
         4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111: bad_op = 1'b0;
         default:                                     bad_op = 1'b1;
      endcase
      return bad_op || (w[2:0] > 3'b100) || (w[23:19] != 5'd0);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_q <= 1'b0;
         stopped   <= 1'b0;
      end else begin
         if (state == WAIT && !bus.redirect_valid) begin
            illegal_q <= is_illegal(bus.mem_data_out);
         end else if (next_state != VALID) begin
            illegal_q <= 1'b0;
         end
         // Once an illegal word is consumed, only a jump (or reset) restarts fetching.
         if (bus.redirect_valid) begin
            stopped <= 1'b0;
         end else if (state == VALID && bus.instr_ready && illegal_q) begin
            stopped <= 1'b1;
         end
      end
   end

   assign bus.illegal = illegal_q;
   assign stop_after  = illegal_q;
`else
   assign stopped    = 1'b0;
   assign stop_after = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
// Directed scenarios plus a randomized run against a next-expected-PC scoreboard.
module tb_instr_fetch_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.ADDR_W(8)) bus ();

   instr_fetch_unit #(.RESET_PC(8'd20), .ADDR_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Synchronous 128x24 memory; output is junk unless the previous edge was an enabled read.
   logic [23:0] mem [128];
   logic [23:0] rd_q;
   always @(posedge clk) begin
      if (bus.mem_EN && !bus.mem_CS) rd_q <= mem[bus.mem_MAR[6:0]];
      else                           rd_q <= 24'($urandom);
   end
   assign bus.mem_data_out = rd_q;

   int pass_cnt  = 0;
   int total_cnt = 0;

   function automatic logic [23:0] legal_word();
      logic [3:0] op;
      case ($urandom_range(0, 8))
         0: op = 4'd0;   1: op = 4'd1;   2: op = 4'd3;
         3: op = 4'd7;   4: op = 4'd11;  5: op = 4'd12;
         6: op = 4'd13;  7: op = 4'd14;  default: op = 4'd15;
      endcase
      return {5'd0, op, 4'($urandom), 8'($urandom), 3'($urandom_range(0, 4))};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.halt = 1'b0;
      bus.instr_ready = 1'b0;
      bus.bus_busy = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr = 8'd0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.halt = 1'b0;
      bus.instr_ready = 1'b1;
      bus.bus_busy = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr = 8'd0;
      tick();
      tick();
      total_cnt++; if (bus.mem_EN !== 1'b0) $display("FAIL reset_en got=%b exp=0", bus.mem_EN); else pass_cnt++;
      total_cnt++; if (bus.mem_MAR !== 8'd0) $display("FAIL reset_mar got=%0d exp=0", bus.mem_MAR); else pass_cnt++;
      total_cnt++; if (bus.mem_CS !== 1'b0) $display("FAIL reset_cs got=%b exp=0", bus.mem_CS); else pass_cnt++;
      total_cnt++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.instr_valid); else pass_cnt++;
      total_cnt++; if (bus.instr_word !== 24'd0) $display("FAIL reset_word got=%h exp=0", bus.instr_word); else pass_cnt++;
      total_cnt++; if ({bus.opcode, bus.reg_sel, bus.operand, bus.mode} !== 19'd0)
         $display("FAIL reset_fields got=%h exp=0", {bus.opcode, bus.reg_sel, bus.operand, bus.mode}); else pass_cnt++;
      total_cnt++; if (bus.instr_pc !== 8'd0) $display("FAIL reset_pc got=%0d exp=0", bus.instr_pc); else pass_cnt++;
`ifdef IFU_ILLEGAL_CHECK_EN
      total_cnt++; if (bus.illegal !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", bus.illegal); else pass_cnt++;
`endif
      // Abandon a read that is in flight.
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b0 || bus.instr_word !== 24'd0)
         $display("FAIL reset_midop got valid=%b word=%h exp valid=0 word=0", bus.instr_valid, bus.instr_word); else pass_cnt++;
      rst = 1'b0;
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b0 || bus.instr_word !== 24'd0)
         $display("FAIL reset_stale got valid=%b word=%h exp valid=0 word=0", bus.instr_valid, bus.instr_word); else pass_cnt++;
   endtask

   task automatic test_first_fetch();
      mem[20] = 24'h0188F0;
      do_reset();
      bus.instr_ready = 1'b1;
      total_cnt++; if (bus.mem_EN !== 1'b0) $display("FAIL first_c0_en got=%b exp=0", bus.mem_EN); else pass_cnt++;
      tick();
      total_cnt++; if (bus.mem_EN !== 1'b1 || bus.mem_MAR !== 8'd20)
         $display("FAIL first_c1_req got en=%b mar=%0d exp en=1 mar=20", bus.mem_EN, bus.mem_MAR); else pass_cnt++;
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b0) $display("FAIL first_c2_valid got=%b exp=0", bus.instr_valid); else pass_cnt++;
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b1) $display("FAIL first_c3_valid got=%b exp=1", bus.instr_valid); else pass_cnt++;
      total_cnt++; if ({bus.opcode, bus.reg_sel, bus.operand, bus.mode} !== {4'd3, 4'd1, 8'd30, 3'd0})
         $display("FAIL first_fields got op=%0d reg=%0d opd=%0d mode=%0d exp op=3 reg=1 opd=30 mode=0",
                  bus.opcode, bus.reg_sel, bus.operand, bus.mode); else pass_cnt++;
      total_cnt++; if (bus.instr_pc !== 8'd20 || bus.instr_word !== 24'h0188F0)
         $display("FAIL first_word got pc=%0d word=%h exp pc=20 word=0188f0", bus.instr_pc, bus.instr_word); else pass_cnt++;
   endtask

   task automatic test_stream();
      logic       exp_en;
      logic       exp_v;
      logic [7:0] a;
      for (int i = 20; i < 24; i++) mem[i] = legal_word();
      do_reset();
      bus.instr_ready = 1'b1;
      for (int c = 0; c < 13; c++) begin
         exp_en = (c % 3 == 1);
         exp_v  = (c >= 3) && (c % 3 == 0);
         total_cnt++; if (bus.mem_EN !== exp_en) $display("FAIL stream_en c=%0d got=%b exp=%b", c, bus.mem_EN, exp_en); else pass_cnt++;
         if (exp_en) begin
            a = 8'(20 + (c - 1) / 3);
            total_cnt++; if (bus.mem_MAR !== a) $display("FAIL stream_mar c=%0d got=%0d exp=%0d", c, bus.mem_MAR, a); else pass_cnt++;
         end
         total_cnt++; if (bus.instr_valid !== exp_v) $display("FAIL stream_valid c=%0d got=%b exp=%b", c, bus.instr_valid, exp_v); else pass_cnt++;
         if (exp_v) begin
            a = 8'(20 + c / 3 - 1);
            total_cnt++; if (bus.instr_pc !== a || bus.instr_word !== mem[a[6:0]])
               $display("FAIL stream_word c=%0d got pc=%0d word=%h exp pc=%0d word=%h",
                        c, bus.instr_pc, bus.instr_word, a, mem[a[6:0]]); else pass_cnt++;
         end
         tick();
      end
   endtask

   task automatic test_stall();
      do_reset();
      tick();
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         total_cnt++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'd20 || bus.instr_word !== mem[20] || bus.mem_EN !== 1'b0)
            $display("FAIL stall_hold k=%0d got valid=%b pc=%0d word=%h en=%b exp valid=1 pc=20 word=%h en=0",
                     k, bus.instr_valid, bus.instr_pc, bus.instr_word, bus.mem_EN, mem[20]); else pass_cnt++;
         if (k < 4) tick();
      end
      bus.instr_ready = 1'b1;
      tick();
      total_cnt++; if (bus.mem_EN !== 1'b1 || bus.mem_MAR !== 8'd21 || bus.instr_valid !== 1'b0)
         $display("FAIL stall_resume got en=%b mar=%0d valid=%b exp en=1 mar=21 valid=0",
                  bus.mem_EN, bus.mem_MAR, bus.instr_valid); else pass_cnt++;
   endtask

   task automatic test_bus_busy();
      do_reset();
      bus.instr_ready = 1'b1;
      bus.bus_busy = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         tick();
         total_cnt++; if (bus.mem_EN !== 1'b0) $display("FAIL busy_en c=%0d got=%b exp=0", c, bus.mem_EN); else pass_cnt++;
      end
      tick();
      bus.bus_busy = 1'b0;
      #1;
      total_cnt++; if (bus.mem_EN !== 1'b1 || bus.mem_MAR !== 8'd20)
         $display("FAIL busy_release got en=%b mar=%0d exp en=1 mar=20", bus.mem_EN, bus.mem_MAR); else pass_cnt++;
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b0) $display("FAIL busy_c4_valid got=%b exp=0", bus.instr_valid); else pass_cnt++;
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'd20)
         $display("FAIL busy_c5_valid got valid=%b pc=%0d exp valid=1 pc=20", bus.instr_valid, bus.instr_pc); else pass_cnt++;
   endtask

   task automatic test_redirect();
      do_reset();
      bus.instr_ready = 1'b1;
      repeat (8) tick();
      // Cycle 8: fetch of address 22 is waiting on memory.
      total_cnt++; if (bus.mem_EN !== 1'b0 || bus.instr_valid !== 1'b0)
         $display("FAIL redir_wait got en=%b valid=%b exp en=0 valid=0", bus.mem_EN, bus.instr_valid); else pass_cnt++;
      bus.redirect_valid = 1'b1;
      bus.redirect_addr = 8'd40;
      tick();
      bus.redirect_valid = 1'b0;
      total_cnt++; if (bus.mem_EN !== 1'b1 || bus.mem_MAR !== 8'd40 || bus.instr_valid !== 1'b0)
         $display("FAIL redir_target got en=%b mar=%0d valid=%b exp en=1 mar=40 valid=0",
                  bus.mem_EN, bus.mem_MAR, bus.instr_valid); else pass_cnt++;
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b0) $display("FAIL redir_drop22 got valid=%b pc=%0d exp valid=0", bus.instr_valid, bus.instr_pc); else pass_cnt++;
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'd40 || bus.instr_word !== mem[40])
         $display("FAIL redir_word40 got valid=%b pc=%0d word=%h exp valid=1 pc=40 word=%h",
                  bus.instr_valid, bus.instr_pc, bus.instr_word, mem[40]); else pass_cnt++;
      // Jump coinciding with a handshake: handshake consumed, jump wins.
      bus.redirect_valid = 1'b1;
      bus.redirect_addr = 8'd127;
      tick();
      bus.redirect_valid = 1'b0;
      total_cnt++; if (bus.mem_EN !== 1'b1 || bus.mem_MAR !== 8'd127 || bus.instr_valid !== 1'b0)
         $display("FAIL redir_hs got en=%b mar=%0d valid=%b exp en=1 mar=127 valid=0",
                  bus.mem_EN, bus.mem_MAR, bus.instr_valid); else pass_cnt++;
      tick();
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'd127 || bus.instr_word !== mem[127])
         $display("FAIL redir_word127 got valid=%b pc=%0d word=%h exp valid=1 pc=127 word=%h",
                  bus.instr_valid, bus.instr_pc, bus.instr_word, mem[127]); else pass_cnt++;
      tick();
      total_cnt++; if (bus.mem_EN !== 1'b1 || bus.mem_MAR !== 8'd0)
         $display("FAIL pc_wrap got en=%b mar=%0d exp en=1 mar=0", bus.mem_EN, bus.mem_MAR); else pass_cnt++;
      tick();
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'd0 || bus.instr_word !== mem[0])
         $display("FAIL wrap_word got valid=%b pc=%0d word=%h exp valid=1 pc=0 word=%h",
                  bus.instr_valid, bus.instr_pc, bus.instr_word, mem[0]); else pass_cnt++;
      // Jump while holding an unaccepted word; bit 7 of the target is ignored.
      bus.instr_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_addr = 8'd200;
      tick();
      bus.redirect_valid = 1'b0;
      total_cnt++; if (bus.instr_valid !== 1'b0 || bus.mem_EN !== 1'b1 || bus.mem_MAR !== 8'd72)
         $display("FAIL redir_valid_drop got valid=%b en=%b mar=%0d exp valid=0 en=1 mar=72",
                  bus.instr_valid, bus.mem_EN, bus.mem_MAR); else pass_cnt++;
   endtask

   task automatic test_halt();
      do_reset();
      tick();
      tick();
      bus.halt = 1'b1;
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'd20)
         $display("FAIL halt_inflight got valid=%b pc=%0d exp valid=1 pc=20", bus.instr_valid, bus.instr_pc); else pass_cnt++;
      bus.instr_ready = 1'b1;
      tick();
      bus.instr_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         total_cnt++; if (bus.mem_EN !== 1'b0 || bus.instr_valid !== 1'b0)
            $display("FAIL halt_idle k=%0d got en=%b valid=%b exp en=0 valid=0", k, bus.mem_EN, bus.instr_valid); else pass_cnt++;
         if (k < 4) tick();
      end
      bus.halt = 1'b0;
      tick();
      total_cnt++; if (bus.mem_EN !== 1'b1 || bus.mem_MAR !== 8'd21)
         $display("FAIL halt_resume got en=%b mar=%0d exp en=1 mar=21", bus.mem_EN, bus.mem_MAR); else pass_cnt++;
   endtask

`ifdef IFU_ILLEGAL_CHECK_EN
   task automatic test_illegal();
      mem[20] = 24'h010000;
      mem[21] = 24'h0188F0;
      do_reset();
      bus.instr_ready = 1'b1;
      tick();
      tick();
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b1 || bus.illegal !== 1'b1)
         $display("FAIL illegal_flag got valid=%b illegal=%b exp valid=1 illegal=1", bus.instr_valid, bus.illegal); else pass_cnt++;
      tick();
      for (int k = 0; k < 6; k++) begin
         total_cnt++; if (bus.mem_EN !== 1'b0 || bus.instr_valid !== 1'b0)
            $display("FAIL illegal_stop k=%0d got en=%b valid=%b exp en=0 valid=0", k, bus.mem_EN, bus.instr_valid); else pass_cnt++;
         tick();
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_addr = 8'd21;
      tick();
      bus.redirect_valid = 1'b0;
      total_cnt++; if (bus.mem_EN !== 1'b1 || bus.mem_MAR !== 8'd21)
         $display("FAIL illegal_restart got en=%b mar=%0d exp en=1 mar=21", bus.mem_EN, bus.mem_MAR); else pass_cnt++;
      tick();
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b1 || bus.illegal !== 1'b0 || bus.instr_pc !== 8'd21)
         $display("FAIL illegal_legal got valid=%b illegal=%b pc=%0d exp valid=1 illegal=0 pc=21",
                  bus.instr_valid, bus.illegal, bus.instr_pc); else pass_cnt++;
      mem[20] = legal_word();
   endtask
`endif

   task automatic test_random();
      int          exp_pc;
      int          quiet;
      int          hs_cnt;
      logic [23:0] ew;
      for (int i = 0; i < 128; i++) mem[i] = legal_word();
      do_reset();
      exp_pc = 20;
      quiet  = 0;
      hs_cnt = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         bus.instr_ready    = ($urandom_range(0, 9) < 6);
         bus.bus_busy       = ($urandom_range(0, 3) == 0);
         bus.redirect_valid = ($urandom_range(0, 24) == 0);
         bus.redirect_addr  = 8'($urandom);
         #1;
         if (bus.bus_busy) begin
            total_cnt++; if (bus.mem_EN !== 1'b0) $display("FAIL rand_busy_en cyc=%0d got=%b exp=0", cyc, bus.mem_EN); else pass_cnt++;
         end
         if (bus.instr_valid === 1'b1 && bus.instr_ready) begin
            ew = mem[exp_pc];
            total_cnt++; if (bus.instr_pc !== 8'(exp_pc) || bus.instr_word !== ew)
               $display("FAIL rand_word cyc=%0d got pc=%0d word=%h exp pc=%0d word=%h",
                        cyc, bus.instr_pc, bus.instr_word, exp_pc, ew); else pass_cnt++;
            total_cnt++; if ({bus.opcode, bus.reg_sel, bus.operand, bus.mode} !== ew[18:0])
               $display("FAIL rand_fields cyc=%0d got=%h exp=%h", cyc,
                        {bus.opcode, bus.reg_sel, bus.operand, bus.mode}, ew[18:0]); else pass_cnt++;
            exp_pc = (exp_pc + 1) % 128;
            hs_cnt++;
            quiet = 0;
         end else begin
            quiet++;
         end
         if (bus.redirect_valid) exp_pc = int'(bus.redirect_addr) % 128;
         if (quiet > 60) begin
            total_cnt++;
            $display("FAIL rand_timeout cyc=%0d got no handshake in %0d cycles exp <=60", cyc, quiet);
            break;
         end
         tick();
      end
      bus.instr_ready = 1'b0;
      bus.bus_busy = 1'b0;
      bus.redirect_valid = 1'b0;
      total_cnt++; if (hs_cnt < 100) $display("FAIL rand_throughput got=%0d exp>=100", hs_cnt); else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 128; i++) mem[i] = legal_word();
      test_reset();
      test_first_fetch();
      test_stream();
      test_stall();
      test_bus_busy();
      test_redirect();
      test_halt();
`ifdef IFU_ILLEGAL_CHECK_EN
      test_illegal();
`endif
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
endmodule
